// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;
  localparam int PORT_LOAD  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Which of fetch/data was served most recently.
  typedef enum logic {
    RR_FETCH = 1'b0,
    RR_DATA  = 1'b1
  } rr_t;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/rr_prio_arbiter.sv
// ============================================================================
// Module   : rr_prio_arbiter
// Brief    : Combinational grant logic: loader first, fetch/data round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_prio_arbiter
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  rr_t                last_rr,
  output logic [NUM_REQ-1:0] gnt,
  output rr_t                next_rr
);

  always_comb begin
    gnt     = '0;
    next_rr = last_rr;
    if (req[PORT_LOAD]) begin
      // Loader grants leave the fetch/data fairness state untouched.
      gnt[PORT_LOAD] = 1'b1;
    end else if (req[PORT_FETCH] && req[PORT_DATA]) begin
      if (last_rr == RR_DATA) begin
        gnt[PORT_FETCH] = 1'b1;
        next_rr         = RR_FETCH;
      end else begin
        gnt[PORT_DATA]  = 1'b1;
        next_rr         = RR_DATA;
      end
    end else if (req[PORT_FETCH]) begin
      gnt[PORT_FETCH] = 1'b1;
      next_rr         = RR_FETCH;
    end else if (req[PORT_DATA]) begin
      gnt[PORT_DATA]  = 1'b1;
      next_rr         = RR_DATA;
    end
  end

endmodule : rr_prio_arbiter

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Serializes fetch, data and loader accesses onto one memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   we,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [ADDR_W-1:0]    addr2,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  input  logic [DATA_W-1:0]    wdata2,
  output logic [NUM_REQ-1:0]   done,
  output logic [DATA_W-1:0]    rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy
);

  state_t              r_state;
  rr_t                 r_last_rr;
  logic [NUM_REQ-1:0]  r_owner;
  logic [NUM_REQ-1:0]  r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_gnt;
  rr_t                 w_next_rr;
  logic [ADDR_W-1:0]   w_addr_vec  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_vec [NUM_REQ];
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_we;

  rr_prio_arbiter u_arb (
    .req     (req),
    .last_rr (r_last_rr),
    .gnt     (w_gnt),
    .next_rr (w_next_rr)
  );

  assign w_addr_vec[PORT_FETCH]  = addr0;
  assign w_addr_vec[PORT_DATA]   = addr1;
  assign w_addr_vec[PORT_LOAD]   = addr2;
  assign w_wdata_vec[PORT_FETCH] = wdata0;
  assign w_wdata_vec[PORT_DATA]  = wdata1;
  assign w_wdata_vec[PORT_LOAD]  = wdata2;

  // Grant is one-hot, so a priority-free select is sufficient.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr  = w_addr_vec[i];
        w_sel_wdata = w_wdata_vec[i];
        w_sel_we    = we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_rr   <= RR_DATA;
      r_owner     <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state     <= ISSUE;
            r_busy      <= 1'b1;
            r_owner     <= w_gnt;
            r_last_rr   <= w_next_rr;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end
        end
        ISSUE: begin
          r_state  <= CAPTURE;
          r_mem_en <= 1'b0;
        end
        CAPTURE: begin
          // Memory output is valid now, one cycle after the strobe was sampled.
          r_state <= RESP;
          if (!r_mem_we) begin
            r_rdata <= mem_rdata;
          end
          r_done  <= r_owner;
        end
        RESP: begin
          r_state <= IDLE;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_done   <= '0;
          r_mem_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req     = 3'b000;
  logic [2:0]  we      = 3'b000;
  logic [7:0]  addr_t  [3];
  logic [15:0] wdata_t [3];
  logic [2:0]  done;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr0     (addr_t[0]),
    .addr1     (addr_t[1]),
    .addr2     (addr_t[2]),
    .wdata0    (wdata_t[0]),
    .wdata1    (wdata_t[1]),
    .wdata2    (wdata_t[2]),
    .done      (done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Synchronous single-port memory: read data appears the cycle after the strobe.
  logic [15:0] mem [256];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h05] <= 16'h0505;
      mem[8'h30] <= 16'hC0DE;
      loaded     <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
  } iss_t;

  typedef struct packed {
    logic [2:0]  done;
    logic [15:0] rdata;
  } rsp_t;

  typedef struct {
    int          port;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  iss_t iq[$];
  rsp_t dq[$];
  vec_t tbl [13];

  int n_vec       = 0;
  int n_err       = 0;
  int cyc         = 0;
  int n_done_seen = 0;
  bit prev_en     = 1'b0;
  bit prev_done   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any issue/done events seen there.
  task automatic tick();
    iss_t ie;
    rsp_t re;
    @(negedge clk);
    cyc++;
    if (mem_en === 1'b1) begin
      check("mem_en_width", 64'(prev_en), 64'd0);
      if (iq.size() == 0) begin
        check("unexpected_issue", 64'(mem_en), 64'd0);
      end else begin
        ie = iq.pop_front();
        check("issue", 64'({mem_addr, mem_we, (mem_we ? mem_wdata : 16'h0000)}), 64'(ie));
      end
    end
    if (done !== 3'b000) begin
      n_done_seen++;
      check("done_width", 64'(prev_done), 64'd0);
      if (dq.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        re = dq.pop_front();
        check("done_rdata", 64'({done, rdata}), 64'(re));
      end
    end
    prev_en   = (mem_en === 1'b1);
    prev_done = (done !== 3'b000);
  endtask

  task automatic set_port(input int p, input bit w, input logic [7:0] a, input logic [15:0] wd);
    we[p]      = w;
    addr_t[p]  = a;
    wdata_t[p] = wd;
  endtask

  task automatic push_exp(input int p, input bit w, input logic [7:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
    iss_t ie;
    rsp_t re;
    ie.addr  = a;
    ie.we    = w;
    ie.wdata = w ? wd : 16'h0000;
    re.done  = 3'(1 << p);
    re.rdata = exp_rd;
    iq.push_back(ie);
    dq.push_back(re);
  endtask

  task automatic wait_done(output logic [2:0] d, output bit ok);
    ok = 1'b0;
    d  = 3'b000;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done !== 3'b000) begin
        d  = done;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done pulse in 24 cycles, expected one (cycle %0d)", cyc);
    end
  endtask

  // Hold req for each port until it has collected its quota of done pulses.
  task automatic run_held(input int c0, input int c1, input int c2);
    int         rem [3];
    int         last_c;
    int         total;
    bit         first;
    bit         ok;
    logic [2:0] d;
    rem[0] = c0; rem[1] = c1; rem[2] = c2;
    total  = c0 + c1 + c2;
    first  = 1'b1;
    last_c = 0;
    for (int p = 0; p < 3; p++) req[p] = (rem[p] > 0);
    for (int k = 0; k < total; k++) begin
      wait_done(d, ok);
      if (!ok) break;
      if (!first) check("done_spacing", 64'(cyc - last_c), 64'd4);
      first  = 1'b0;
      last_c = cyc;
      for (int p = 0; p < 3; p++) begin
        if (d[p]) begin
          rem[p]--;
          if (rem[p] <= 0) req[p] = 1'b0;
        end
      end
    end
    req = 3'b000;
    tick();
  endtask

  initial begin
    int         cnt [3];
    int         snap;
    bit         ok;
    logic [2:0] d;
    iss_t       ie;

    for (int p = 0; p < 3; p++) begin
      addr_t[p]  = 8'h00;
      wdata_t[p] = 16'h0000;
    end

    tbl[0]  = '{1, 1'b1, 8'h22, 16'h1234, 16'hBEEF};
    tbl[1]  = '{1, 1'b0, 8'h22, 16'h0000, 16'h1234};
    tbl[2]  = '{2, 1'b1, 8'h40, 16'hA5A5, 16'h1234};
    tbl[3]  = '{0, 1'b0, 8'h40, 16'h0000, 16'hA5A5};
    tbl[4]  = '{2, 1'b0, 8'h30, 16'h0000, 16'hC0DE};
    tbl[5]  = '{1, 1'b1, 8'h50, 16'h0F0F, 16'hC0DE};
    tbl[6]  = '{0, 1'b0, 8'h50, 16'h0000, 16'h0F0F};
    tbl[7]  = '{2, 1'b0, 8'h22, 16'h0000, 16'h1234};
    tbl[8]  = '{0, 1'b1, 8'h60, 16'hFFFF, 16'h1234};
    tbl[9]  = '{1, 1'b0, 8'h60, 16'h0000, 16'hFFFF};
    tbl[10] = '{0, 1'b0, 8'h00, 16'h0000, 16'h0000};
    tbl[11] = '{2, 1'b1, 8'hFF, 16'h8001, 16'h0000};
    tbl[12] = '{1, 1'b0, 8'hFF, 16'h0000, 16'h8001};

    repeat (3) tick();
    check("reset_state", 64'({done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single fetch read with cycle-exact latency.
    set_port(0, 1'b0, 8'h10, 16'h0000);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    req = 3'b001;
    tick();
    check("fetch_issue_cycle", 64'({mem_en, busy, done}), 64'({1'b1, 1'b1, 3'b000}));
    tick();
    check("fetch_capture_cycle", 64'({mem_en, busy, done}), 64'({1'b0, 1'b1, 3'b000}));
    tick();
    check("fetch_resp_cycle", 64'({done, rdata}), 64'({3'b001, 16'hBEEF}));
    req = 3'b000;
    tick();
    check("fetch_idle_cycle", 64'({busy, done, mem_en}), 64'd0);

    for (int i = 0; i < 13; i++) begin
      set_port(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      push_exp(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
      cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
      cnt[tbl[i].port] = 1;
      run_held(cnt[0], cnt[1], cnt[2]);
    end

    // Fetch served last, then loader grants: data must win once loader leaves.
    set_port(0, 1'b0, 8'h10, 16'h0000);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    run_held(1, 0, 0);
    set_port(2, 1'b0, 8'h30, 16'h0000);
    set_port(1, 1'b0, 8'h22, 16'h0000);
    push_exp(2, 1'b0, 8'h30, 16'h0000, 16'hC0DE);
    push_exp(2, 1'b0, 8'h30, 16'h0000, 16'hC0DE);
    push_exp(1, 1'b0, 8'h22, 16'h0000, 16'h1234);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    run_held(1, 1, 2);

    // Reset during CAPTURE of a read of 0x05: access abandoned, no done.
    set_port(0, 1'b0, 8'h05, 16'h0000);
    ie.addr = 8'h05; ie.we = 1'b0; ie.wdata = 16'h0000;
    iq.push_back(ie);
    req = 3'b001;
    tick();
    tick();
    check("capture_before_reset", 64'({busy, mem_en, done}), 64'({1'b1, 1'b0, 3'b000}));
    reset_n = 1'b0;
    tick();
    check("reset_mid_access", 64'({done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy}), 64'd0);
    req     = 3'b000;
    reset_n = 1'b1;
    snap    = n_done_seen;
    repeat (6) tick();
    check("no_done_after_reset", 64'(n_done_seen - snap), 64'd0);

    // Fetch/data contention straight out of reset: fetch wins the first tie.
    set_port(0, 1'b0, 8'h10, 16'h0000);
    set_port(1, 1'b0, 8'h22, 16'h0000);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    push_exp(1, 1'b0, 8'h22, 16'h0000, 16'h1234);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    push_exp(1, 1'b0, 8'h22, 16'h0000, 16'h1234);
    run_held(2, 2, 0);

    // Loader priority from reset: fetch follows once the loader drops.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    set_port(2, 1'b0, 8'h30, 16'h0000);
    push_exp(2, 1'b0, 8'h30, 16'h0000, 16'hC0DE);
    push_exp(2, 1'b0, 8'h30, 16'h0000, 16'hC0DE);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    push_exp(1, 1'b0, 8'h22, 16'h0000, 16'h1234);
    run_held(1, 1, 2);

    // Fetch drops req in ISSUE; a data request raised meanwhile waits for IDLE.
    set_port(0, 1'b0, 8'h10, 16'h0000);
    push_exp(0, 1'b0, 8'h10, 16'h0000, 16'hBEEF);
    req = 3'b001;
    tick();
    req[0] = 1'b0;
    set_port(1, 1'b0, 8'h22, 16'h0000);
    push_exp(1, 1'b0, 8'h22, 16'h0000, 16'h1234);
    req[1] = 1'b1;
    tick();
    tick();
    check("abandon_done", 64'({done, rdata}), 64'({3'b001, 16'hBEEF}));
    tick();
    check("no_grant_before_idle", 64'({mem_en, busy}), 64'd0);
    tick();
    check("grant_from_idle", 64'({mem_en, mem_addr}), 64'({1'b1, 8'h22}));
    wait_done(d, ok);
    req = 3'b000;
    tick();
    tick();

    check("queues_drained", 64'(iq.size() + dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port unified memory among three requesters: instruction fetch, data load/store, and the external program loader. It sits between the control path/datapath and the memory macro and replaces direct strobing of memory enables. Every access is serialized through a fixed four-state sequence, and each access is completed with a one-cycle done pulse to its owner.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req[2:0]  in  3  access request. Bit 0 is fetch, bit 1 is data, bit 2 is loader.
- we[2:0]  in  3  per-requester write enable; 1 means write
- addr0/addr1/addr2  in  ADDR_W each  per-requester address
- wdata0/wdata1/wdata2  in  DATA_W each  per-requester write data
- done[2:0]  out  3  one-hot completion pulse
- rdata  out  DATA_W  read data of the last completed read
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en is sampled
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. Transitions are unconditional except from IDLE:
  - IDLE -> ISSUE when req != 0; otherwise stay in IDLE.
  - ISSUE -> CAPTURE -> RESP -> IDLE.
- Arbitration is evaluated only on the IDLE clock edge.
  - Loader (bit 2) has strict priority.
  - Fetch and data share a round-robin pointer, last_rr. If both request, the one not served last wins.
  - last_rr updates only when fetch or data is granted; a loader grant leaves it unchanged.
  - last_rr resets to "data", so fetch wins the first tie.
- IDLE edge with a grant latches owner, mem_addr, mem_we and mem_wdata from the winner, and sets mem_en<=1.
- mem_en is high for exactly the ISSUE cycle.
- CAPTURE edge:
  - If the access is a read, rdata<=mem_rdata.
  - done[owner]<=1.
- RESP: done[owner] is high for exactly one cycle. rdata is stable from RESP until the next read's CAPTURE edge.
- Writes leave rdata unchanged.
- No arbitration occurs in RESP. This gives the owner the RESP cycle to drop req.
- Requester obligations: hold req, we, addr and wdata stable from assertion until done. Drop req in the cycle after done, or keep it high to request again.
- If a requester drops req mid-access, the access still completes and done still pulses.
- done is never asserted for a port that was not granted.
- At most one done bit is high in any cycle.

## Timing
- Reset values:
  - state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - done=000, rdata=0, busy=0, last_rr=data.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: req sampled at edge E0 gives mem_en high in E0..E1, data captured at E2, done high in E2..E3.
- Throughput: one access per 4 cycles, including a mandatory IDLE cycle.
- Reset asserted mid-access:
  - The next edge forces the reset values.
  - The in-flight access is abandoned, and no done pulse is issued for it.
- A request arriving while busy waits until IDLE. A request held continuously is never dropped.
- Starvation bound:
  - Fetch and data each wait at most one other fetch/data access, unless the loader holds req.
  - The loader can starve fetch and data. This is intended, because loading occurs only while the core is halted.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, CAPTURE, RESP);
  - the port index constants (PORT_FETCH=0, PORT_DATA=1, PORT_LOAD=2);
  - the requester count NUM_REQ=3.
- One sub-module, rr_prio_arbiter:
  - Inputs: req[2:0], last_rr.
  - Outputs: one-hot gnt[2:0] and next_rr.
  - It is purely combinational and is instantiated once.
- The top level holds the FSM, the output registers, and the request-field mux.

## Test plan
- Single fetch read:
  - Stimulus: memory preloaded mem[0x10]=0xBEEF; req=001, addr0=0x10.
  - Response: mem_en high for one cycle with mem_addr=0x10 and mem_we=0. done=001 on the third cycle after the sampling edge, with rdata=0xBEEF.
- Data write then read-back:
  - Stimulus: req=010, we1=1, addr1=0x22, wdata1=0x1234. After done, request a read of 0x22.
  - Response: mem_we=1 with mem_wdata=0x1234. rdata is unchanged after the write and equals 0x1234 after the read.
- Fetch/data contention:
  - Stimulus: req=011 held continuously from reset.
  - Response: grants alternate fetch, data, fetch, data. done pulses at 4-cycle spacing.
- Loader priority:
  - Stimulus: req=111 held.
  - Response: all grants go to the loader. When it drops req, fetch is served next, because last_rr was unchanged by loader grants.
- Reset mid-access:
  - Stimulus: assert reset_n=0 in CAPTURE of a read of 0x05.
  - Response: next cycle state=IDLE, done=000, rdata=0, mem_en=0. No done pulse follows.
- Requester abandons request:
  - Stimulus: req0 drops in ISSUE.
  - Response: done[0] still pulses in RESP, and the next grant happens only from IDLE.
